// File: rtl/mem_pkg.sv
// Shared memory-interface definitions for the controller, datapath and responder.
// Holds the responder state encoding and the default address/data widths.
package mem_pkg;

  localparam int unsigned MemAddrW = 13;
  localparam int unsigned MemDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port RAM of DEPTH x DATA_W, synchronous write and synchronous read.
// Ports:
//   clk, rst  - clock; synchronous active-high reset (clears read register only)
//   en, we    - access enable; write when we=1, read into rdata when we=0
//   addr      - full-width address; addresses >= DEPTH are out of range
//   wdata     - write data
//   rdata     - registered read data, holds until the next read
// Out-of-range writes are dropped and out-of-range reads return zero.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MemAddrW,
  parameter int unsigned DATA_W = MemDataW,
  parameter int unsigned DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AddrW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthLim = AddrW1'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IdxW-1:0]   idx;

  assign in_range = ({1'b0, addr} < DepthLim);
  assign idx      = addr[IdxW-1:0];

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU controller.
// Accepts one read or write per transaction, waits WAIT_CYCLES, commits the access on
// the edge entering RESP and pulses mem_ready for one cycle.
// Ports:
//   clk, rst                       - clock; synchronous active-high reset
//   mem_read, mem_write            - request levels, held by the controller until mem_ready
//   mem_addr, mem_wdata            - request address / write data
//   mem_rdata                      - registered read data, changes only on a read commit
//   mem_ready                      - one-cycle completion pulse
//   mem_err                        - one-cycle error pulse (out of range, or read+write)
//   prog_we, prog_addr, prog_data  - preload write port, honoured only when idle
//   prog_ack                       - preload accepted this cycle (combinational)
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = MemAddrW,
  parameter int unsigned DATA_W      = MemDataW,
  parameter int unsigned DEPTH       = 8192,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack
);

  localparam int unsigned CntW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned AddrW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DepthLim = AddrW1'(DEPTH);
  localparam logic [CntW-1:0]   CntLoad  = CntW'(WAIT_CYCLES);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);

  mem_state_e        st_q, st_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q, err_q;

  logic              accept, both_req, commit, commit_en;
  logic              cmt_wr, cmt_oor;
  logic [ADDR_W-1:0] cmt_addr;
  logic [DATA_W-1:0] cmt_wdata;

  logic              arr_en, arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    both_req = 1'b0;
    commit   = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (mem_read ^ mem_write) begin
          accept = 1'b1;
          cnt_d  = CntLoad;
          if (WAIT_CYCLES == 0) begin
            st_d   = StResp;
            commit = 1'b1;
          end else begin
            st_d = StWait;
          end
        end else if (mem_read && mem_write) begin
          both_req = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == CntOne) begin
          st_d   = StResp;
          cnt_d  = '0;
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StResp: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so it must use the live
  // request rather than the latched copy.
  always_comb begin
    if (st_q == StIdle) begin
      cmt_wr    = mem_write;
      cmt_addr  = mem_addr;
      cmt_wdata = mem_wdata;
    end else begin
      cmt_wr    = op_wr_q;
      cmt_addr  = addr_q;
      cmt_wdata = wdata_q;
    end
  end

  assign cmt_oor   = !({1'b0, cmt_addr} < DepthLim);
  assign commit_en = commit && !rst;
  assign prog_ack  = prog_we && (st_q == StIdle) && !mem_read && !mem_write;

  // Commit and preload are mutually exclusive: preload needs no request pending.
  always_comb begin
    arr_en    = commit_en || prog_ack;
    arr_we    = commit_en ? cmt_wr : 1'b1;
    arr_addr  = commit_en ? cmt_addr : prog_addr;
    arr_wdata = commit_en ? cmt_wdata : prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      err_q   <= both_req || (commit && cmt_oor);
      if (accept) begin
        op_wr_q <= mem_write;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk  (clk),
    .rst  (rst),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Three instances share stimulus:
//   0: DEPTH=8192, WAIT_CYCLES=2   1: DEPTH=4096, WAIT_CYCLES=2   2: DEPTH=8192, WAIT_CYCLES=0
// Each test resets all instances first and checks only the instance it targets.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, prog_we;
  logic [12:0] mem_addr, prog_addr;
  logic [7:0]  mem_wdata, prog_data;
  logic [7:0]  rdata [3];
  logic        rdy   [3];
  logic        err   [3];
  logic        ack   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(8192), .WAIT_CYCLES(2)) u_main (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_err(err[0]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(ack[0])
  );

  mem_responder #(.DEPTH(4096), .WAIT_CYCLES(2)) u_oor (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_err(err[1]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(ack[1])
  );

  mem_responder #(.DEPTH(8192), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata[2]), .mem_ready(rdy[2]), .mem_err(err[2]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ack(ack[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; prog_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Issue one request and wait for the target's mem_ready; lat = edges from accept edge
  // to ready, or -1 on timeout. Returns in the RESP cycle with the request dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [7:0] d, input int sel, output int lat);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rdy[sel] === 1'b1) begin
        lat = n;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", rdy[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err[0]); end
    n_checks++; if (rdata[0] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata[0]); end
    n_checks++; if (rdata[2] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata_w0: got %h want 00", rdata[2]); end
    n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack[0]); end
  endtask

  task automatic test_preload_read();
    int lat;
    reset_all();
    prog_we = 1'b1; prog_addr = 13'h005; prog_data = 8'hA7;
    #1;
    n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL preload_ack: got %b want 1", ack[0]); end
    tick();
    prog_we = 1'b0;
    do_req(1'b1, 1'b0, 13'h005, 8'h00, 0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
    n_checks++; if (rdata[0] !== 8'hA7) begin n_fail++; $display("FAIL read_data: got %h want a7", rdata[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err[0]); end
    tick();
    n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %b want 0", rdy[0]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    reset_all();
    do_req(1'b1, 1'b0, 13'h005, 8'h00, 0, lat);
    tick();
    do_req(1'b0, 1'b1, 13'h010, 8'h3C, 0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
    n_checks++; if (rdata[0] !== 8'hA7) begin n_fail++; $display("FAIL write_keeps_rdata: got %h want a7", rdata[0]); end
    // Next request presented in the RESP cycle itself.
    mem_read = 1'b1; mem_addr = 13'h010;
    gap = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rdy[0] === 1'b1) begin gap = n; break; end
    end
    mem_read = 1'b0;
    n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d want 4", gap); end
    n_checks++; if (rdata[0] !== 8'h3C) begin n_fail++; $display("FAIL b2b_rdata: got %h want 3c", rdata[0]); end
    tick();
  endtask

  task automatic test_both_high();
    int lat;
    reset_all();
    preload(13'h030, 8'h44);
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 13'h030; mem_wdata = 8'hFF;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    n_checks++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", err[0]); end
    n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL both_noready: got %b want 0", rdy[0]); end
    prog_we = 1'b1; prog_addr = 13'h031; prog_data = 8'h01;
    #1;
    n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL both_idle_ack: got %b want 1", ack[0]); end
    tick();
    prog_we = 1'b0;
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL both_err_pulse: got %b want 0", err[0]); end
    do_req(1'b1, 1'b0, 13'h030, 8'h00, 0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL both_then_lat: got %0d want 3", lat); end
    n_checks++; if (rdata[0] !== 8'h44) begin n_fail++; $display("FAIL both_unchanged: got %h want 44", rdata[0]); end
    tick();
  endtask

  task automatic test_out_of_range();
    int lat;
    reset_all();
    preload(13'h0FFF, 8'h55);
    do_req(1'b1, 1'b0, 13'h0FFF, 8'h00, 1, lat);
    n_checks++; if (rdata[1] !== 8'h55) begin n_fail++; $display("FAIL oor_pre_read: got %h want 55", rdata[1]); end
    tick();
    do_req(1'b1, 1'b0, 13'h1FFF, 8'h00, 1, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL oor_latency: got %0d want 3", lat); end
    n_checks++; if (err[1] !== 1'b1) begin n_fail++; $display("FAIL oor_read_err: got %b want 1", err[1]); end
    n_checks++; if (rdata[1] !== 8'h00) begin n_fail++; $display("FAIL oor_read_zero: got %h want 00", rdata[1]); end
    tick();
    n_checks++; if (err[1] !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 0", err[1]); end
    do_req(1'b0, 1'b1, 13'h1FFF, 8'hEE, 1, lat);
    n_checks++; if (err[1] !== 1'b1) begin n_fail++; $display("FAIL oor_write_err: got %b want 1", err[1]); end
    tick();
    do_req(1'b1, 1'b0, 13'h0FFF, 8'h00, 1, lat);
    n_checks++; if (rdata[1] !== 8'h55) begin n_fail++; $display("FAIL oor_write_dropped: got %h want 55", rdata[1]); end
    n_checks++; if (err[1] !== 1'b0) begin n_fail++; $display("FAIL oor_inrange_err: got %b want 0", err[1]); end
    tick();
  endtask

  task automatic test_prog_during_wait();
    int lat;
    reset_all();
    preload(13'h040, 8'h12);
    mem_read = 1'b1; mem_addr = 13'h050;
    tick();
    prog_we = 1'b1; prog_addr = 13'h040; prog_data = 8'h99;
    #1;
    n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL wait_prog_ack: got %b want 0", ack[0]); end
    tick();
    prog_we = 1'b0;
    tick();
    mem_read = 1'b0;
    tick();
    do_req(1'b1, 1'b0, 13'h040, 8'h00, 0, lat);
    n_checks++; if (rdata[0] !== 8'h12) begin n_fail++; $display("FAIL wait_prog_ignored: got %h want 12", rdata[0]); end
    tick();
    prog_we = 1'b1; prog_addr = 13'h040; prog_data = 8'h77;
    #1;
    n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL idle_prog_ack: got %b want 1", ack[0]); end
    tick();
    prog_we = 1'b0;
    do_req(1'b1, 1'b0, 13'h040, 8'h00, 0, lat);
    n_checks++; if (rdata[0] !== 8'h77) begin n_fail++; $display("FAIL idle_prog_written: got %h want 77", rdata[0]); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    int seen;
    reset_all();
    preload(13'h020, 8'h11);
    do_req(1'b1, 1'b0, 13'h005, 8'h00, 0, lat);
    n_checks++; if (rdata[0] !== 8'hA7) begin n_fail++; $display("FAIL rst_pre_rdata: got %h want a7", rdata[0]); end
    tick();
    mem_write = 1'b1; mem_addr = 13'h020; mem_wdata = 8'h99;
    tick();
    mem_write = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready: got %b want 0", rdy[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_err: got %b want 0", err[0]); end
    n_checks++; if (rdata[0] !== 8'h00) begin n_fail++; $display("FAIL rst_wait_rdata: got %h want 00", rdata[0]); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy[0] === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_ready: got %0d want 0", seen); end
    do_req(1'b1, 1'b0, 13'h020, 8'h00, 0, lat);
    n_checks++; if (rdata[0] !== 8'h11) begin n_fail++; $display("FAIL rst_wait_nocommit: got %h want 11", rdata[0]); end
    tick();
    // Reset landing on the commit edge itself.
    mem_write = 1'b1; mem_addr = 13'h020; mem_wdata = 8'h99;
    tick();
    tick();
    mem_write = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_commit_ready: got %b want 0", rdy[0]); end
    do_req(1'b1, 1'b0, 13'h020, 8'h00, 0, lat);
    n_checks++; if (rdata[0] !== 8'h11) begin n_fail++; $display("FAIL rst_commit_blocked: got %h want 11", rdata[0]); end
    tick();
  endtask

  task automatic test_wait_zero();
    int lat;
    reset_all();
    do_req(1'b1, 1'b0, 13'h005, 8'h00, 2, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w0_read_latency: got %0d want 1", lat); end
    n_checks++; if (rdata[2] !== 8'hA7) begin n_fail++; $display("FAIL w0_read_data: got %h want a7", rdata[2]); end
    tick();
    do_req(1'b0, 1'b1, 13'h060, 8'h5A, 2, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w0_write_latency: got %0d want 1", lat); end
    tick();
    do_req(1'b1, 1'b0, 13'h060, 8'h00, 2, lat);
    n_checks++; if (rdata[2] !== 8'h5A) begin n_fail++; $display("FAIL w0_raw: got %h want 5a", rdata[2]); end
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; prog_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; prog_addr = '0; prog_data = '0;
    test_reset();
    test_preload_read();
    test_back_to_back();
    test_both_high();
    test_out_of_range();
    test_prog_during_wait();
    test_reset_mid_wait();
    test_wait_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU controller's memory interface.
- Serves `mem_read` / `mem_write` requests, addressed from PC or TR, against an internal unified instruction/data store.
- Inserts a configurable number of wait states and signals completion with `mem_ready`.
- Provides a preload port so benches and boot logic can fill the store while the CPU is idle.

Parameters:
- ADDR_W, 13, address width in bits.
- DATA_W, 8, data word width in bits.
- DEPTH, 8192, number of implemented words; addresses at or above DEPTH are out of range.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 allowed).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  read request level from controller
- mem_write  in  1  write request level from controller
- mem_addr  in  ADDR_W  request address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  registered read data
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle error pulse, coincident with mem_ready or alone (see below)
- prog_we  in  1  preload write strobe
- prog_addr  in  ADDR_W  preload address
- prog_data  in  DATA_W  preload data
- prog_ack  out  1  preload accepted this cycle (combinational)

Behaviour:
- Reset (sync, active-high; clk and rst named as elsewhere in the codebase): state IDLE, mem_ready=0, mem_err=0, mem_rdata=0, wait counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Exactly one of mem_read/mem_write high: latch op, addr, wdata. Load counter with WAIT_CYCLES. Go to WAIT, or to RESP if WAIT_CYCLES=0.
  - Both high: no access, mem_err=1 for one cycle, no mem_ready, stay IDLE.
- WAIT: counter decrements each cycle. Inputs are ignored; the latched copies are used. When counter reaches 1 (after WAIT_CYCLES cycles in WAIT), go to RESP.
- Access commit happens on the clock edge entering RESP:
  - Read loads mem_rdata from the array at the latched address.
  - Write updates the array.
- RESP: mem_ready=1 for exactly one cycle, then IDLE.
- Total latency from request-accept edge to mem_ready high is WAIT_CYCLES+1 cycles.
- mem_rdata holds its value until the next read commit. Writes do not change it.
- The controller holds request levels until mem_ready. A request still asserted in the RESP cycle is not re-sampled. Back-to-back requests are accepted in the IDLE cycle immediately after RESP, so throughput is one access per WAIT_CYCLES+2 cycles.
- Out of range (latched addr >= DEPTH):
  - Read returns 0 into mem_rdata.
  - Write is dropped.
  - mem_err=1 together with mem_ready in RESP.
- Read-after-write to the same address returns the newly written value, since the commits are sequential.
- Preload:
  - prog_ack = prog_we & IDLE & ~mem_read & ~mem_write.
  - On ack, the array is written at prog_addr on that edge.
  - A controller request has priority. prog_we outside IDLE is ignored, with prog_ack=0.
  - Out-of-range preload is dropped but still acked.
- Reset mid-operation: the transaction is abandoned, with no commit and no mem_ready.
- Reset coincident with a commit edge: the commit does not occur.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - default ADDR_W/DATA_W constants shared with the controller and datapath.
- One sub-module, mem_array: single-port synchronous-write, synchronous-read RAM of DEPTH×DATA_W.
  - Its write port is muxed between the commit path and the preload path.
  - The responder FSM and counter stay in mem_responder.

Test Plan:
- Preload addr 0x005=0xA7, then mem_read addr 0x005 with WAIT_CYCLES=2 -> mem_ready high exactly 3 cycles after accept, mem_rdata=0xA7, mem_err=0.
- mem_write addr 0x010 data 0x3C, then back-to-back mem_read 0x010 -> second mem_ready 4 cycles after the first, mem_rdata=0x3C; mem_rdata unchanged by the write.
- Both mem_read and mem_write high in IDLE -> mem_err pulse 1 cycle, no mem_ready, array unchanged, state IDLE.
- With DEPTH=4096, mem_read addr 0x1FFF -> mem_ready+mem_err same cycle, mem_rdata=0x00; write to 0x1FFF leaves the array unchanged.
- prog_we during WAIT -> prog_ack=0, target word unchanged; prog_we in IDLE with no request -> prog_ack=1, word written.
- rst asserted during WAIT of a write to 0x020 (old 0x11, new 0x99) -> no mem_ready, word stays 0x11, outputs zero the cycle after reset.
- WAIT_CYCLES=0 -> mem_ready 1 cycle after accept.
